jtag_dr_ctrl: RTL and testbench
===============================

JTAG_DR_CTRL -- requirements
Module: jtag_dr_ctrl

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 4, instruction register width.
REQ-002 SHALL provide parameter NUM_REGS, default 2, number of boundary-scan data registers sequenced; legal range 1 .. 2^IR_WIDTH-2.
REQ-003 SHALL provide parameter IDCODE, default 32'h249511C3, IDCODE register value; bit0 is 1.
REQ-004 SHALL have clk_i  in  1  system clock; the only clock; TCK is oversampled.
REQ-005 SHALL have rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have tck_i, tms_i, tdi_i  in  1 each  JTAG pins, already synchronised to clk_i.
REQ-007 SHALL have tdo_o  out  1  and tdo_oe_o  out  1  as the JTAG data output and output enable.
REQ-008 SHALL have enable_o  out  1  as a one-cycle TCK-rise strobe to all chains.
REQ-009 SHALL have capture_dr_o, shift_dr_o, update_dr_o  out  NUM_REGS each  as per-register qualified DR controls.
REQ-010 SHALL have scan_in_o  out  1  as the serial input to all chains, equal to tdi_i.
REQ-011 SHALL have scan_out_i  in  NUM_REGS  as the per-register chain serial outputs.
REQ-012 SHALL have mode_o  out  1  as the boundary-scan mode select.
REQ-013 SHALL have tap_state_o  out  4  as the current TAP state, IEEE 1149.1 encoding.
REQ-014 SHALL have ir_o  out  IR_WIDTH  as the current instruction.

Function
REQ-015 SHALL register tck_i twice (q1, q2) and set rise = q1 & ~q2 and fall = ~q1 & q2; each pulse lasts one clk_i cycle per TCK edge; enable_o = rise.
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing only in cycles where rise=1, with next state selected by tms_i sampled in that cycle.
REQ-017 SHALL enter TEST_LOGIC_RESET after 5 consecutive rises with tms_i=1, from any state.
REQ-018 SHALL decode instructions as follows: ir_o = k (k < NUM_REGS) selects user register k; ir_o = 2^IR_WIDTH-2 selects IDCODE; ir_o = all-ones selects BYPASS; all other codes select BYPASS.
REQ-019 SHALL drive capture_dr_o[k], shift_dr_o[k] and update_dr_o[k] as registered levels equal to (state is CAPTURE_DR, SHIFT_DR or UPDATE_DR respectively) AND register k selected, so that chains sampling on enable_o see the pre-transition state; unselected bits SHALL be 0.
REQ-020 SHALL load the IR shifter with 'b0..01 in CAPTURE_IR and shift it LSB-first from tdi_i in SHIFT_IR; ir_o SHALL load from the shifter on a rise in UPDATE_IR only.
REQ-021 SHALL load the bypass bit with 0 in CAPTURE_DR and with tdi_i in SHIFT_DR; SHALL load the 32-bit IDCODE shifter with IDCODE in CAPTURE_DR and shift it LSB-first in SHIFT_DR; these actions occur only while the respective register is selected.
REQ-022 SHALL update tdo_o on fall only, from the source matching the current state: SHIFT_IR gives IR shifter bit0; SHIFT_DR gives scan_out_i[k], IDCODE bit0 or bypass bit per selection.
REQ-023 SHALL, on fall, set tdo_oe_o=1 in SHIFT_IR or SHIFT_DR and set tdo_oe_o=0 otherwise.
REQ-024 SHALL drive mode_o=1 while a user register is selected and 0 otherwise.
REQ-025 SHALL reload ir_o with the default instruction (REQ-031) on the rise that enters TEST_LOGIC_RESET.
REQ-026 SHALL, when rise and fall would occur in the same cycle (impossible by construction), never assert both.

Reset
REQ-027 SHALL, on rst_i=1 at a clk_i edge, set the state to TEST_LOGIC_RESET, ir_o to the default instruction, and q1, q2, tdo_o, tdo_oe_o, all shifters and all DR controls to 0; mode_o follows ir_o.
REQ-028 SHALL give rst_i priority over any concurrent rise; a shift in progress is abandoned and chains receive no update_dr.
REQ-029 SHALL assert no rise in the first cycle after reset, even with tck_i=1, because q1 and q2 restart at 0.

Configuration
REQ-030 SHALL compile the IDCODE register in when the macro JTAG_DR_CTRL_IDCODE_EN is defined.
REQ-031 SHALL, with JTAG_DR_CTRL_IDCODE_EN defined, use IDCODE as the default instruction and shift IDCODE out in SHIFT_DR.
REQ-032 SHALL, without JTAG_DR_CTRL_IDCODE_EN, use BYPASS as the default instruction, decode code 2^IR_WIDTH-2 as BYPASS, and include no IDCODE storage.

Verification
REQ-033 SHALL test reset: assert rst_i, then hold tms_i=1 for 5 TCK -> tap_state_o=TEST_LOGIC_RESET and ir_o=4'hE (macro defined) or 4'hF (undefined).
REQ-034 SHALL test IDCODE readout (macro defined): after reset, go to SHIFT_DR and clock 32 TCK -> tdo_o sequence LSB-first equals 32'h249511C3 and tdo_oe_o=1 throughout.
REQ-035 SHALL test user register select: load IR=4'h1, then go through CAPTURE_DR, 8 SHIFT_DR TCK and UPDATE_DR -> capture/shift/update strobes appear only on bit1, each coincident with enable_o, and mode_o=1.
REQ-036 SHALL test BYPASS: load IR=4'hF and shift tdi pattern 1011 -> tdo_o outputs 0,1,0,1 delayed by one TCK.
REQ-037 SHALL test reset mid-operation: assert rst_i in SHIFT_DR after 3 TCK -> update_dr_o stays 0 and the state is TEST_LOGIC_RESET the next cycle.
REQ-038 SHALL test IR capture: go to SHIFT_IR and shift 4 TCK -> tdo_o reads 1,0,0,0.

Source files
------------

// File: rtl/jtag_dr_ctrl.sv
// rtl/jtag_dr_ctrl.sv - IEEE 1149.1 TAP controller and DR sequencer oversampling TCK on clk_i
// Define JTAG_DR_CTRL_IDCODE_EN to compile in the IDCODE register and make it the default instruction.
module jtag_dr_ctrl #(
  parameter int          IR_WIDTH = 4,
  parameter int          NUM_REGS = 2,
  parameter logic [31:0] IDCODE   = 32'h249511C3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                enable_o,
  output logic [NUM_REGS-1:0] capture_dr_o,
  output logic [NUM_REGS-1:0] shift_dr_o,
  output logic [NUM_REGS-1:0] update_dr_o,
  output logic                scan_in_o,
  input  logic [NUM_REGS-1:0] scan_out_i,
  output logic                mode_o,
  output logic [3:0]          tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o
);

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_BYPASS = '1;
`ifdef JTAG_DR_CTRL_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = {{(IR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_BYPASS;
`endif

  tap_state_t          state;
  logic                q1, q2, rise, fall;
  logic [IR_WIDTH-1:0] ir_q, ir_sr;
  logic                bypass_q;
  logic [NUM_REGS-1:0] user_sel;
  logic                bypass_sel;
  logic                dr_tdo;
`ifdef JTAG_DR_CTRL_IDCODE_EN
  logic                idcode_sel;
  logic [31:0]         idcode_sr;
`else
  logic                unused_idcode;
  assign unused_idcode = ^IDCODE;
`endif

  assign rise = q1 & ~q2;
  assign fall = ~q1 & q2;

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   next_state = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  endfunction

  always_comb begin
    user_sel = '0;
    for (int k = 0; k < NUM_REGS; k++)
      user_sel[k] = (ir_q == IR_WIDTH'(k));
  end

`ifdef JTAG_DR_CTRL_IDCODE_EN
  assign idcode_sel = (ir_q == IR_IDCODE);
  assign bypass_sel = ~|user_sel & ~idcode_sel;
`else
  assign bypass_sel = ~|user_sel;
`endif

  always_comb begin
    dr_tdo = bypass_q;
    if (|user_sel)
      dr_tdo = |(scan_out_i & user_sel);
`ifdef JTAG_DR_CTRL_IDCODE_EN
    else if (idcode_sel)
      dr_tdo = idcode_sr[0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q1           <= 1'b0;
      q2           <= 1'b0;
      state        <= TEST_LOGIC_RESET;
      ir_q         <= IR_DEFAULT;
      ir_sr        <= '0;
      bypass_q     <= 1'b0;
      tdo_o        <= 1'b0;
      tdo_oe_o     <= 1'b0;
      capture_dr_o <= '0;
      shift_dr_o   <= '0;
      update_dr_o  <= '0;
`ifdef JTAG_DR_CTRL_IDCODE_EN
      idcode_sr    <= '0;
`endif
    end else begin
      q1 <= tck_i;
      q2 <= q1;
      // Levels track the state held since the last rise, so they are settled by the next rise.
      capture_dr_o <= (state == CAPTURE_DR) ? user_sel : '0;
      shift_dr_o   <= (state == SHIFT_DR)   ? user_sel : '0;
      update_dr_o  <= (state == UPDATE_DR)  ? user_sel : '0;
      if (rise) begin
        state <= next_state(state, tms_i);
        case (state)
          CAPTURE_IR: ir_sr <= IR_WIDTH'(1);
          SHIFT_IR:   ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
          UPDATE_IR:  ir_q  <= ir_sr;
          CAPTURE_DR: begin
            if (bypass_sel) bypass_q <= 1'b0;
`ifdef JTAG_DR_CTRL_IDCODE_EN
            if (idcode_sel) idcode_sr <= IDCODE;
`endif
          end
          SHIFT_DR: begin
            if (bypass_sel) bypass_q <= tdi_i;
`ifdef JTAG_DR_CTRL_IDCODE_EN
            if (idcode_sel) idcode_sr <= {tdi_i, idcode_sr[31:1]};
`endif
          end
          default: ;
        endcase
        if (next_state(state, tms_i) == TEST_LOGIC_RESET)
          ir_q <= IR_DEFAULT;
      end
      if (fall) begin
        tdo_oe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
        if (state == SHIFT_IR)
          tdo_o <= ir_sr[0];
        else if (state == SHIFT_DR)
          tdo_o <= dr_tdo;
      end
    end
  end

  assign enable_o    = rise;
  assign scan_in_o   = tdi_i;
  assign mode_o      = |user_sel;
  assign tap_state_o = state;
  assign ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_dr_ctrl.sv
// tb/tb_jtag_dr_ctrl.sv - scoreboard bench for jtag_dr_ctrl driving directed TAP sequences
// Honours JTAG_DR_CTRL_IDCODE_EN the same way as the design.
`timescale 1ns/1ps
module tb_jtag_dr_ctrl;

  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2, S_SELIR = 4'h4,
                         S_UPDR  = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7, S_EX1IR = 4'h9,
                         S_SHIR  = 4'hA, S_RTI   = 4'hC, S_UPIR  = 4'hD, S_CAPIR = 4'hE,
                         S_TLR   = 4'hF;
  localparam logic [31:0] ID = 32'h249511C3;
`ifdef JTAG_DR_CTRL_IDCODE_EN
  localparam logic [3:0] IR_DEF = 4'hE;
`else
  localparam logic [3:0] IR_DEF = 4'hF;
`endif

  logic       clk, rst_i, tck_i, tms_i, tdi_i;
  logic       tdo_o, tdo_oe_o, enable_o, scan_in_o, mode_o;
  logic [1:0] capture_dr_o, shift_dr_o, update_dr_o, scan_out_i;
  logic [3:0] tap_state_o, ir_o;

  jtag_dr_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .enable_o(enable_o),
    .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
    .scan_in_o(scan_in_o), .scan_out_i(scan_out_i), .mode_o(mode_o),
    .tap_state_o(tap_state_o), .ir_o(ir_o)
  );

  typedef struct {
    int         kind;
    string      tag;
    logic [3:0] st;
    logic [3:0] ir;
    logic [1:0] cap, sh, upd;
    logic       mode, chk_tdo, tdo, oe;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] tb_ir = IR_DEF;
  string      tb_tag = "reset";
  logic       rst_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst_i;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: one scoreboard entry per reset cycle or TCK rise strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_q === 1'b1 || enable_o === 1'b1) begin
        if (sb.size() == 0) begin
          cmp("unexpected_event", 32'(tap_state_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          cmp({e.tag, "/kind"}, (rst_q === 1'b1) ? 32'd1 : 32'd0, 32'(e.kind));
          cmp({e.tag, "/state"}, 32'(tap_state_o), 32'(e.st));
          cmp({e.tag, "/ir"}, 32'(ir_o), 32'(e.ir));
          cmp({e.tag, "/capture_dr"}, 32'(capture_dr_o), 32'(e.cap));
          cmp({e.tag, "/shift_dr"}, 32'(shift_dr_o), 32'(e.sh));
          cmp({e.tag, "/update_dr"}, 32'(update_dr_o), 32'(e.upd));
          cmp({e.tag, "/mode"}, 32'(mode_o), 32'(e.mode));
          if (e.chk_tdo) begin
            cmp({e.tag, "/tdo"}, 32'(tdo_o), 32'(e.tdo));
            cmp({e.tag, "/tdo_oe"}, 32'(tdo_oe_o), 32'(e.oe));
          end
          if (e.kind == 1) cmp({e.tag, "/enable"}, 32'(enable_o), 32'd0);
          cmp({e.tag, "/scan_in"}, 32'(scan_in_o), 32'(tdi_i));
        end
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] st, input logic chk, input logic tdo, input logic oe);
    exp_t       e;
    logic [1:0] onehot;
    onehot    = (tb_ir == 4'd0) ? 2'b01 : (tb_ir == 4'd1) ? 2'b10 : 2'b00;
    e.kind    = 0;
    e.tag     = tb_tag;
    e.st      = st;
    e.ir      = tb_ir;
    e.cap     = (st == S_CAPDR) ? onehot : 2'b00;
    e.sh      = (st == S_SHDR)  ? onehot : 2'b00;
    e.upd     = (st == S_UPDR)  ? onehot : 2'b00;
    e.mode    = |onehot;
    e.chk_tdo = chk;
    e.tdo     = tdo;
    e.oe      = oe;
    return e;
  endfunction

  task automatic push_reset();
    exp_t e;
    tb_ir = IR_DEF;
    e = mk(S_TLR, 1'b1, 1'b0, 1'b0);
    e.kind = 1;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic tms, input logic tdi, input logic [3:0] st,
                       input logic chk, input logic tdo, input logic oe);
    sb.push_back(mk(st, chk, tdo, oe));
    tms_i = tms;
    tdi_i = tdi;
    repeat (4) @(posedge clk);
    #1 tck_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 tck_i = 1'b0;
  endtask

  task automatic step(input logic tms, input logic [3:0] st);
    pulse(tms, 1'b0, st, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dr_enter();
    step(1'b1, S_RTI);
    step(1'b0, S_SELDR);
    step(1'b0, S_CAPDR);
  endtask

  task automatic dr_exit();
    step(1'b1, S_EX1DR);
    step(1'b0, S_UPDR);
  endtask

  task automatic load_ir(input logic [3:0] code);
    logic [3:0] t;
    tb_tag = "ir_load";
    step(1'b1, S_RTI);
    step(1'b1, S_SELDR);
    step(1'b0, S_SELIR);
    step(1'b0, S_CAPIR);
    for (int i = 0; i < 4; i++) begin
      t = code >> i;
      pulse(i == 3, t[0], S_SHIR, 1'b1, i == 0, 1'b1);
    end
    step(1'b1, S_EX1IR);
    step(1'b0, S_UPIR);
    tb_ir = code;
  endtask

  task automatic bypass_shift(input logic [3:0] code);
    logic [3:0] pin, pout, a, b;
    pin  = 4'b1101;
    pout = 4'b1010;
    load_ir(code);
    tb_tag = "bypass";
    dr_enter();
    for (int i = 0; i < 4; i++) begin
      a = pin >> i;
      b = pout >> i;
      pulse(i == 3, a[0], S_SHDR, 1'b1, b[0], 1'b1);
    end
    dr_exit();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [31:0] idw;
    rst_i = 1'b1; tck_i = 1'b1; tms_i = 1'b1; tdi_i = 1'b0; scan_out_i = 2'b10;
    push_reset();
    push_reset();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    // tck_i held high through reset gives exactly one rise, two cycles after release.
    sb.push_back(mk(S_TLR, 1'b0, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1 tck_i = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) step(1'b1, S_TLR);
    step(1'b0, S_TLR);

`ifdef JTAG_DR_CTRL_IDCODE_EN
    tb_tag = "idcode";
    dr_enter();
    for (int i = 0; i < 32; i++) begin
      idw = ID >> i;
      pulse(i == 31, 1'b0, S_SHDR, 1'b1, idw[0], 1'b1);
    end
    dr_exit();
`else
    idw = ID;
    tb_tag = "bypass_e";
    bypass_shift(4'hE);
`endif

    load_ir(4'h1);
    tb_tag = "user1";
    dr_enter();
    for (int i = 0; i < 8; i++) pulse(i == 7, 1'b0, S_SHDR, 1'b1, 1'b1, 1'b1);
    dr_exit();

    scan_out_i = 2'b01;
    bypass_shift(4'hF);
    bypass_shift(4'h5);

    load_ir(4'h1);
    tb_tag = "mid_reset";
    dr_enter();
    for (int i = 0; i < 3; i++) step(1'b0, S_SHDR);
    push_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    step(1'b1, S_TLR);
    step(1'b0, S_TLR);

    load_ir(4'h0);
    tb_tag = "tms_five";
    dr_enter();
    step(1'b1, S_SHDR);
    step(1'b1, S_EX1DR);
    step(1'b1, S_UPDR);
    step(1'b1, S_SELDR);
    step(1'b1, S_SELIR);
    tb_ir = IR_DEF;
    step(1'b1, S_TLR);
    step(1'b0, S_TLR);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
